// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO of any depth with optional FWFT
// read mode, programmable almost flags, occupancy and error pulses.
module sync_fifo_flags #(
  parameter int DEPTH     = 22,
  parameter int WIDTH     = 8,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic             ren,
  output logic [WIDTH-1:0] dout,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr_nx;
  logic [PW-1:0]    rptr_nx;
  logic [CW-1:0]    cnt;
  logic             wr_acc;
  logic             rd_acc;

  assign wfull         = (cnt == CW'(DEPTH));
  assign rempty        = (cnt == '0);
  assign walmost_full  = (cnt >= CW'(AF_THRESH));
  assign ralmost_empty = (cnt <= CW'(AE_THRESH));
  assign count         = cnt;

  // Acceptance looks only at registered flags, so a simultaneous
  // read never frees space for a write in the same cycle (and vice versa).
  assign wr_acc = wen & ~wfull;
  assign rd_acc = ren & ~rempty;

  // Explicit wrap keeps non-power-of-two depths in range.
  assign wptr_nx = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
  assign rptr_nx = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr_nx;
      if (rd_acc) rptr <= rptr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wen & wfull;
      underflow <= ren & rempty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is shown directly; forced to zero while empty.
      assign dout = rempty ? '0 : mem[rptr];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rptr];
        end
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a registered-read and an
// FWFT instance driven by directed vectors.
module tb_sync_fifo_flags;

  localparam int D = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic       wen0, ren0, wen1, ren1;
  logic [7:0] din0, din1, dout0, dout1;
  logic       wfull0, rempty0, af0, ae0, ovf0, unf0;
  logic       wfull1, rempty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  sync_fifo_flags #(.DEPTH(D), .WIDTH(8), .FWFT(1'b0)) u0 (
    .clk(clk), .rst_n(rst0_n), .wen(wen0), .din(din0), .ren(ren0),
    .dout(dout0), .wfull(wfull0), .rempty(rempty0),
    .walmost_full(af0), .ralmost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_flags #(.DEPTH(D), .WIDTH(8), .FWFT(1'b1)) u1 (
    .clk(clk), .rst_n(rst1_n), .wen(wen1), .din(din1), .ren(ren1),
    .dout(dout1), .wfull(wfull1), .rempty(rempty1),
    .walmost_full(af1), .ralmost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    bit         inst;
    int         step;
    int         cnt;
    bit         ovf;
    bit         unf;
    bit         dchk;
    logic [7:0] dv;
  } exp_t;

  exp_t       sbq[$];
  exp_t       me;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         step = 0;
  int         mcnt[2];
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] mdout0;

  task automatic chk(input string nm, input int st,
                     input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, st, act, want);
    end
  endtask

  // One cycle of stimulus; model computes the expected post-edge state.
  task automatic cyc(input bit inst, input bit w, input logic [7:0] d,
                     input bit r);
    exp_t e;
    bit   wa, ra;
    @(negedge clk);
    wa = w && (mcnt[inst] != D);
    ra = r && (mcnt[inst] != 0);
    e.ovf = w && (mcnt[inst] == D);
    e.unf = r && (mcnt[inst] == 0);
    wen0 = 1'b0; ren0 = 1'b0; wen1 = 1'b0; ren1 = 1'b0;
    if (!inst) begin
      wen0 = w; din0 = d; ren0 = r;
      if (ra) mdout0 = mq0.pop_front();
      if (wa) mq0.push_back(d);
    end else begin
      wen1 = w; din1 = d; ren1 = r;
      if (ra) void'(mq1.pop_front());
      if (wa) mq1.push_back(d);
    end
    mcnt[inst] = mcnt[inst] + int'(wa) - int'(ra);
    e.inst = inst;
    e.step = step;
    e.cnt  = mcnt[inst];
    if (!inst) begin
      e.dchk = 1'b1;
      e.dv   = mdout0;
    end else begin
      e.dchk = (mcnt[1] != 0);
      e.dv   = e.dchk ? mq1[0] : 8'h00;
    end
    step++;
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    wen0 = 1'b0; ren0 = 1'b0; wen1 = 1'b0; ren1 = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      me = sbq.pop_front();
      if (!me.inst) begin
        chk("count0", me.step, count0, me.cnt);
        chk("wfull0", me.step, wfull0, me.cnt == D);
        chk("rempty0", me.step, rempty0, me.cnt == 0);
        chk("afull0", me.step, af0, me.cnt >= D - 2);
        chk("aempty0", me.step, ae0, me.cnt <= 2);
        chk("ovf0", me.step, ovf0, me.ovf);
        chk("unf0", me.step, unf0, me.unf);
        chk("dout0", me.step, dout0, me.dv);
      end else begin
        chk("count1", me.step, count1, me.cnt);
        chk("wfull1", me.step, wfull1, me.cnt == D);
        chk("rempty1", me.step, rempty1, me.cnt == 0);
        chk("ovf1", me.step, ovf1, me.ovf);
        chk("unf1", me.step, unf1, me.unf);
        if (me.dchk) chk("dout1", me.step, dout1, me.dv);
      end
    end
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    wen0 = 1'b0; ren0 = 1'b0; din0 = '0;
    wen1 = 1'b0; ren1 = 1'b0; din1 = '0;
    mcnt[0] = 0; mcnt[1] = 0; mdout0 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_count", -1, count0, 0);
    chk("rst_rempty", -1, rempty0, 1);
    chk("rst_wfull", -1, wfull0, 0);
    chk("rst_afull", -1, af0, 0);
    chk("rst_aempty", -1, ae0, 1);
    chk("rst_dout", -1, dout0, 0);
    chk("rst_ovf", -1, ovf0, 0);
    chk("rst_unf", -1, unf0, 0);
    chk("rst_count1", -1, count1, 0);
    chk("rst_rempty1", -1, rempty1, 1);
    rst0_n = 1'b1; rst1_n = 1'b1;

    // Fill, then one rejected write.
    for (int i = 0; i < D; i++) cyc(0, 1'b1, 8'(i), 1'b0);
    cyc(0, 1'b1, 8'hEE, 1'b0);
    cyc(0, 1'b0, 8'h00, 1'b0);
    // Drain, then one rejected read; dout must hold 0x15.
    for (int i = 0; i < D; i++) cyc(0, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b0, 8'h00, 1'b0);

    // Wrap: pointers cross 21 -> 0 across rounds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 15; i++) cyc(0, 1'b1, 8'(r * 40 + i), 1'b0);
      for (int i = 0; i < 15; i++) cyc(0, 1'b0, 8'h00, 1'b1);
    end

    // Simultaneous requests at count 0, 10 and 22.
    cyc(0, 1'b1, 8'hC0, 1'b1);
    for (int i = 1; i < 10; i++) cyc(0, 1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 8'(8'hD0 + i), 1'b1);
    for (int i = 0; i < 12; i++) cyc(0, 1'b1, 8'(8'hE0 + i), 1'b0);
    cyc(0, 1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 21; i++) cyc(0, 1'b0, 8'h00, 1'b1);

    // FWFT instance.
    cyc(1, 1'b1, 8'hA5, 1'b0);
    cyc(1, 1'b1, 8'h3C, 1'b0);
    cyc(1, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1, 1'b1, 8'(8'h50 + i), 1'b0);
    idle();
    @(posedge clk);
    #2;

    // Asynchronous reset mid-cycle with count 5.
    chk("pre_rst_count1", -2, count1, 5);
    @(negedge clk);
    #2 rst1_n = 1'b0;
    #1;
    chk("mid_rst_count1", -2, count1, 0);
    chk("mid_rst_rempty1", -2, rempty1, 1);
    @(negedge clk);
    rst1_n = 1'b1;
    mcnt[1] = 0;
    mq1.delete();
    cyc(1, 1'b1, 8'h77, 1'b0);
    cyc(1, 1'b0, 8'h00, 1'b0);
    idle();

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", -3, sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
